// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweeper: walks every input vector of an N_IN-input
// combinational block, captures its output column and scores it against a mask.
module truth_table_sweeper #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   output logic [N_IN-1:0]      vec_out,
   input  logic                 s_in,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic [2**N_IN-1:0]   mismatch_mask,
   output logic [N_IN:0]        err_count,
   output logic                 pass
);
   localparam int              ROWS       = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(ROWS - 1);
   localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

   // With no settle time a vector is sampled on the cycle right after it is driven.
   localparam state_t FIRST_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [ROWS-1:0] snap_q, snap_d;
   logic [ROWS-1:0] table_q, table_d;
   logic [ROWS-1:0] mm_q, mm_d;
   logic [N_IN:0]   err_q, err_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic            miss;
   logic [ROWS-1:0] table_wr;
   logic [ROWS-1:0] mm_wr;

   assign miss = s_in ^ snap_q[idx_q];

   // Per-row capture: only the row addressed by idx takes the sampled value.
   genvar gi;
   for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign table_wr[gi] = (idx_q == N_IN'(gi)) ? s_in : table_q[gi];
      assign mm_wr[gi]    = (idx_q == N_IN'(gi)) ? miss : mm_q[gi];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      table_d = table_q;
      mm_d    = mm_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               snap_d  = expected;
               idx_d   = '0;
               vec_d   = '0;
               table_d = '0;
               mm_d    = '0;
               err_d   = '0;
               pass_d  = 1'b0;
               cnt_d   = SETTLE_CNT;
               busy_d  = 1'b1;
               state_d = FIRST_STATE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            table_d = table_wr;
            mm_d    = mm_wr;
            err_d   = err_q + {{N_IN{1'b0}}, miss};
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               vec_d   = '0;
               idx_d   = '0;
            end else begin
               idx_d   = idx_q + N_IN'(1);
               vec_d   = idx_q + N_IN'(1);
               cnt_d   = SETTLE_CNT;
               state_d = FIRST_STATE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         cnt_q   <= '0;
         snap_q  <= '0;
         table_q <= '0;
         mm_q    <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         table_q <= table_d;
         mm_q    <= mm_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign vec_out       = vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign table_out     = table_q;
   assign mismatch_mask = mm_q;
   assign err_count     = err_q;
   assign pass          = pass_q;

endmodule
